result_bus_arb: RTL and testbench

Producer-side driver for the shared result bus. It accepts results from two execution sources (slot 0 = ALU, slot 1 = load/store) through valid/ready handshakes and buffers each source in a small FIFO. Each cycle it grants at most one source, driving that source's raw bus lane and its one-hot read enable. This guarantees the OR-merge on the result bus never sees two enables high at once.

---
 rtl/result_bus_arb_pkg.sv | 36 +++
 rtl/result_bus_arb_if.sv | 28 ++
 rtl/result_bus_arb_src_fifo.sv | 51 +++++
 rtl/result_bus_arb.sv | 84 ++++++++
 tb/tb_result_bus_arb.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_bus_arb_pkg.sv
// Shared constants, source encoding and the arbitration helper for the result bus driver.
// Default widths live here as macros so every file of this slice agrees on them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RB_DEPTH
`define RB_DEPTH 2
`endif
`ifndef RB_SRC_ALU
`define RB_SRC_ALU 0
`endif
`ifndef RB_SRC_LSU
`define RB_SRC_LSU 1
`endif

package result_bus_arb_pkg;

    typedef enum logic {
        SRC_ALU = 1'(`RB_SRC_ALU),
        SRC_LSU = 1'(`RB_SRC_LSU)
    } src_e;

    // Returns {grant1, grant0}; prefer0 only matters when both sources compete.
    function automatic logic [1:0] arbitrate(input logic cand0, input logic cand1,
                                             input logic prefer0);
        logic [1:0] grant;
        grant = 2'b00;
        if (cand0 && cand1) begin
            grant = prefer0 ? 2'b01 : 2'b10;
        end else begin
            grant = {cand1, cand0};
        end
        return grant;
    endfunction

endpackage

// File: rtl/result_bus_arb_if.sv
// Handshake and result-bus signal bundle between the two execution sources and the bus driver.
interface result_bus_arb_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic                  i_src0_valid;
    logic [DATA_WIDTH-1:0] i_src0_data;
    logic                  o_src0_ready;
    logic                  i_src1_valid;
    logic [DATA_WIDTH-1:0] i_src1_data;
    logic                  o_src1_ready;
    logic                  i_bus_stall;
    logic [DATA_WIDTH-1:0] o_raw_bus_0;
    logic [DATA_WIDTH-1:0] o_raw_bus_1;
    logic                  o_raw_bus_0_ren;
    logic                  o_raw_bus_1_ren;

    modport slave (
        input  i_src0_valid, i_src0_data, i_src1_valid, i_src1_data, i_bus_stall,
        output o_src0_ready, o_src1_ready, o_raw_bus_0, o_raw_bus_1,
               o_raw_bus_0_ren, o_raw_bus_1_ren
    );

    modport master (
        output i_src0_valid, i_src0_data, i_src1_valid, i_src1_data, i_bus_stall,
        input  o_src0_ready, o_src1_ready, o_raw_bus_0, o_raw_bus_1,
               o_raw_bus_0_ren, o_raw_bus_1_ren
    );
endinterface

// File: rtl/result_bus_arb_src_fifo.sv
// rb_src_fifo: DEPTH-entry circular buffer holding one source's results until granted.
// DEPTH must be a power of two so the pointers wrap for free.
module rb_src_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/result_bus_arb.sv
// result_bus_arb: buffers ALU and LSU results and grants at most one lane per cycle onto the bus.
// Define RESULT_BUS_ARB_FIXED_PRIO_EN to make the ALU always win contention (round-robin otherwise).
module result_bus_arb
    import result_bus_arb_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int DEPTH      = `RB_DEPTH
) (
    input logic             clk,
    input logic             rst_n,
    result_bus_arb_if.slave bus
);
    logic                  ready0, ready1;
    logic                  push0, push1;
    logic                  full0, full1;
    logic                  empty0, empty1;
    logic                  grant0, grant1;
    logic                  prefer0;
    logic [DATA_WIDTH-1:0] head0, head1;
    logic [DATA_WIDTH-1:0] lane0_q, lane1_q;
    logic                  ren0_q, ren1_q;

    // Ready looks only at registered occupancy, so a same-cycle pop never opens the door early.
    assign ready0 = !rst_n && !full0;
    assign ready1 = !rst_n && !full1;
    assign push0  = bus.i_src0_valid && ready0;
    assign push1  = bus.i_src1_valid && ready1;

    rb_src_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_alu (
        .clk(clk), .rst(rst_n), .push(push0), .push_data(bus.i_src0_data),
        .pop(grant0), .full(full0), .empty(empty0), .head(head0)
    );

    rb_src_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_lsu (
        .clk(clk), .rst(rst_n), .push(push1), .push_data(bus.i_src1_data),
        .pop(grant1), .full(full1), .empty(empty1), .head(head1)
    );

`ifdef RESULT_BUS_ARB_FIXED_PRIO_EN
    assign prefer0 = 1'b1;
`else
    src_e rr;

    assign prefer0 = (rr == SRC_ALU);

    // The pointer only moves when both sources actually competed for the bus.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rr <= SRC_ALU;
        end else if ((grant0 || grant1) && !empty0 && !empty1) begin
            rr <= (rr == SRC_ALU) ? SRC_LSU : SRC_ALU;
        end
    end
`endif

    always_comb begin
        {grant1, grant0} = 2'b00;
        if (!bus.i_bus_stall) begin
            {grant1, grant0} = arbitrate(!empty0, !empty1, prefer0);
        end
    end

    // Losing or idle lanes keep their last word; only the enables drop.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ren0_q  <= 1'b0;
            ren1_q  <= 1'b0;
            lane0_q <= '0;
            lane1_q <= '0;
        end else begin
            ren0_q <= grant0;
            ren1_q <= grant1;
            if (grant0) lane0_q <= head0;
            if (grant1) lane1_q <= head1;
        end
    end

    assign bus.o_src0_ready    = ready0;
    assign bus.o_src1_ready    = ready1;
    assign bus.o_raw_bus_0     = lane0_q;
    assign bus.o_raw_bus_1     = lane1_q;
    assign bus.o_raw_bus_0_ren = ren0_q;
    assign bus.o_raw_bus_1_ren = ren1_q;
endmodule

// File: tb/tb_result_bus_arb.sv
// Scoreboard bench for result_bus_arb: directed pushes queue the expected grant order, a monitor checks the bus.
// Building with RESULT_BUS_ARB_FIXED_PRIO_EN switches the contention expectations to fixed priority.
module tb_result_bus_arb;
    import result_bus_arb_pkg::*;

    localparam int DW = `DATA_WIDTH;

    typedef struct {
        int          lane;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t expQ[$];
    exp_t monE;
    int   checks   = 0;
    int   failures = 0;

    result_bus_arb_if #(.DATA_WIDTH(DW)) bus();

    result_bus_arb #(.DATA_WIDTH(DW), .DEPTH(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectGrant(input int lane, input logic [DW-1:0] data);
        exp_t e;
        e.lane = lane;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Offers one word on a source and holds it until the handshake completes.
    task automatic applyStimulus(input int lane, input logic [DW-1:0] data);
        logic r;
        int   tries;
        r     = 1'b0;
        tries = 0;
        if (lane == 0) begin
            bus.i_src0_valid = 1'b1;
            bus.i_src0_data  = data;
        end else begin
            bus.i_src1_valid = 1'b1;
            bus.i_src1_data  = data;
        end
        while (!r && tries < 50) begin
            @(negedge clk);
            r = (lane == 0) ? bus.o_src0_ready : bus.o_src1_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (lane == 0) bus.i_src0_valid = 1'b0;
        else           bus.i_src1_valid = 1'b0;
        if (!r) begin
            checks++;
            failures++;
            $display("[TB] FAIL push_timeout: lane %0d data %h never accepted, required acceptance", lane, data);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("drain_pending", DW'(expQ.size()), DW'(0));
        tick();
        checkOutput("idle_ren0", DW'(bus.o_raw_bus_0_ren), DW'(0));
        checkOutput("idle_ren1", DW'(bus.o_raw_bus_1_ren), DW'(0));
    endtask

    // Monitor: every granted beat must match the head of the expected queue.
    always @(negedge clk) begin
        checkOutput("ren_onehot", DW'(bus.o_raw_bus_0_ren & bus.o_raw_bus_1_ren), DW'(0));
        if (bus.o_raw_bus_0_ren || bus.o_raw_bus_1_ren) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_grant: ren0 %0b ren1 %0b bus0 %h bus1 %h, required no grant",
                         bus.o_raw_bus_0_ren, bus.o_raw_bus_1_ren, bus.o_raw_bus_0, bus.o_raw_bus_1);
            end else begin
                monE = expQ.pop_front();
                checkOutput("grant_lane", DW'(bus.o_raw_bus_1_ren ? 1 : 0), DW'(monE.lane));
                checkOutput("grant_data", bus.o_raw_bus_1_ren ? bus.o_raw_bus_1 : bus.o_raw_bus_0,
                            monE.data);
            end
        end
    end

    initial begin
        rst_n            = 1'b1;
        bus.i_src0_valid = 1'b0;
        bus.i_src0_data  = '0;
        bus.i_src1_valid = 1'b0;
        bus.i_src1_data  = '0;
        bus.i_bus_stall  = 1'b0;

        // Reset state, then a single ALU result with one-cycle latency.
        repeat (3) tick();
        checkOutput("reset_ren0", DW'(bus.o_raw_bus_0_ren), DW'(0));
        checkOutput("reset_ren1", DW'(bus.o_raw_bus_1_ren), DW'(0));
        checkOutput("reset_bus0", bus.o_raw_bus_0, DW'(0));
        checkOutput("reset_bus1", bus.o_raw_bus_1, DW'(0));
        checkOutput("reset_ready0", DW'(bus.o_src0_ready), DW'(0));
        checkOutput("reset_ready1", DW'(bus.o_src1_ready), DW'(0));
        rst_n = 1'b0;
        #1;
        checkOutput("post_reset_ready0", DW'(bus.o_src0_ready), DW'(1));
        checkOutput("post_reset_ready1", DW'(bus.o_src1_ready), DW'(1));
        expectGrant(0, 32'hA5A5_0001);
        applyStimulus(0, 32'hA5A5_0001);
        checkOutput("no_bypass_ren0", DW'(bus.o_raw_bus_0_ren), DW'(0));
        tick();
        checkOutput("single_ren0", DW'(bus.o_raw_bus_0_ren), DW'(1));
        checkOutput("single_bus0", bus.o_raw_bus_0, 32'hA5A5_0001);
        checkOutput("single_ren1", DW'(bus.o_raw_bus_1_ren), DW'(0));
        tick();
        checkOutput("single_ren0_drop", DW'(bus.o_raw_bus_0_ren), DW'(0));
        checkOutput("single_bus0_hold", bus.o_raw_bus_0, 32'hA5A5_0001);

        // Both sources streaming: alternating grants (or ALU first under fixed priority).
`ifdef RESULT_BUS_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 8; i++) expectGrant(0, DW'(32'h100 + i));
        for (int i = 0; i < 8; i++) expectGrant(1, DW'(32'h200 + i));
`else
        for (int i = 0; i < 8; i++) begin
            expectGrant(0, DW'(32'h100 + i));
            expectGrant(1, DW'(32'h200 + i));
        end
`endif
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(0, DW'(32'h100 + i));
            end
            begin
                for (int j = 0; j < 8; j++) applyStimulus(1, DW'(32'h200 + j));
            end
        join
        waitDrain();

        // Fill the LSU FIFO under stall; a third offer must be refused.
        bus.i_bus_stall = 1'b1;
        applyStimulus(1, 32'h11);
        applyStimulus(1, 32'h22);
        checkOutput("full_ready1", DW'(bus.o_src1_ready), DW'(0));
        checkOutput("stall_fill_ren0", DW'(bus.o_raw_bus_0_ren), DW'(0));
        checkOutput("stall_fill_ren1", DW'(bus.o_raw_bus_1_ren), DW'(0));
        bus.i_src1_valid = 1'b1;
        bus.i_src1_data  = 32'h33;
        tick();
        checkOutput("refused_ren1", DW'(bus.o_raw_bus_1_ren), DW'(0));
        bus.i_src1_valid = 1'b0;
        bus.i_bus_stall  = 1'b0;
        expectGrant(1, 32'h11);
        expectGrant(1, 32'h22);
        tick();
        checkOutput("unstall_ren1_a", DW'(bus.o_raw_bus_1_ren), DW'(1));
        checkOutput("unstall_bus1_a", bus.o_raw_bus_1, 32'h11);
        tick();
        checkOutput("unstall_ren1_b", DW'(bus.o_raw_bus_1_ren), DW'(1));
        checkOutput("unstall_bus1_b", bus.o_raw_bus_1, 32'h22);
        waitDrain();

        // Three-cycle stall in the middle of an ALU stream.
        for (int i = 1; i <= 6; i++) expectGrant(0, DW'(32'h300 + i));
        fork
            begin
                for (int i = 1; i <= 6; i++) applyStimulus(0, DW'(32'h300 + i));
            end
            begin
                tick();
                tick();
                bus.i_bus_stall = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    checkOutput("stall_ren0", DW'(bus.o_raw_bus_0_ren), DW'(0));
                    checkOutput("stall_ren1", DW'(bus.o_raw_bus_1_ren), DW'(0));
                end
                bus.i_bus_stall = 1'b0;
                tick();
                checkOutput("stall_resume_ren0", DW'(bus.o_raw_bus_0_ren), DW'(1));
            end
        join
        waitDrain();

        // Reset with both FIFOs full discards everything.
        bus.i_bus_stall = 1'b1;
        fork
            begin
                applyStimulus(0, 32'h501);
                applyStimulus(0, 32'h502);
            end
            begin
                applyStimulus(1, 32'h601);
                applyStimulus(1, 32'h602);
            end
        join
        checkOutput("both_full_ready0", DW'(bus.o_src0_ready), DW'(0));
        checkOutput("both_full_ready1", DW'(bus.o_src1_ready), DW'(0));
        rst_n = 1'b1;
        tick();
        checkOutput("midreset_ren0", DW'(bus.o_raw_bus_0_ren), DW'(0));
        checkOutput("midreset_ren1", DW'(bus.o_raw_bus_1_ren), DW'(0));
        checkOutput("midreset_ready0", DW'(bus.o_src0_ready), DW'(0));
        checkOutput("midreset_ready1", DW'(bus.o_src1_ready), DW'(0));
        checkOutput("midreset_bus0", bus.o_raw_bus_0, DW'(0));
        rst_n           = 1'b0;
        bus.i_bus_stall = 1'b0;
        #1;
        checkOutput("rerun_ready0", DW'(bus.o_src0_ready), DW'(1));
        checkOutput("rerun_ready1", DW'(bus.o_src1_ready), DW'(1));
        repeat (4) tick();
        expectGrant(0, 32'h777);
        expectGrant(1, 32'h888);
        fork
            applyStimulus(0, 32'h777);
            applyStimulus(1, 32'h888);
        join
        tick();
        checkOutput("rr_reset_ren0", DW'(bus.o_raw_bus_0_ren), DW'(1));
        checkOutput("rr_reset_bus0", bus.o_raw_bus_0, 32'h777);
        tick();
        checkOutput("rr_reset_ren1", DW'(bus.o_raw_bus_1_ren), DW'(1));
        checkOutput("rr_reset_bus1", bus.o_raw_bus_1, 32'h888);
        waitDrain();

`ifdef RESULT_BUS_ARB_FIXED_PRIO_EN
        // ALU keeps the bus while it has data; the LSU sits full.
        for (int i = 0; i < 8; i++) expectGrant(0, DW'(32'h900 + i));
        for (int i = 0; i < 3; i++) expectGrant(1, DW'(32'hA00 + i));
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(0, DW'(32'h900 + i));
            end
            begin
                for (int j = 0; j < 3; j++) applyStimulus(1, DW'(32'hA00 + j));
            end
            begin
                repeat (2) tick();
                for (int k = 0; k < 6; k++) begin
                    tick();
                    checkOutput("prio_ren0", DW'(bus.o_raw_bus_0_ren), DW'(1));
                    checkOutput("prio_ren1", DW'(bus.o_raw_bus_1_ren), DW'(0));
                    checkOutput("prio_ready1", DW'(bus.o_src1_ready), DW'(0));
                end
            end
        join
        waitDrain();
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
